// File: rtl/karatsuba_pkg.sv
// Shared parameters, requester-index type and helpers for the shared-multiplier arbiter.
package karatsuba_pkg;

  localparam int N_DEFAULT    = 16;
  localparam int NREQ_DEFAULT = 4;
  localparam int IDW_MAX      = 4;

  // Wide enough for any supported requester count (up to 16).
  typedef logic [IDW_MAX-1:0] req_idx_t;

  function automatic int idw_f(input int nreq);
    if (nreq <= 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(nreq);
    end
  endfunction

  // Next index in round-robin order, wrapping nreq-1 back to 0.
  function automatic req_idx_t wrap_inc(input req_idx_t idx, input int nreq);
    if (int'(idx) + 32'sd1 >= nreq) begin
      return 4'd0;
    end else begin
      return idx + 4'd1;
    end
  endfunction

endpackage

// File: rtl/karatsuba_mult.sv
// Generated one-level Karatsuba multiplier: unsigned N x N -> 2N, purely combinational.
module karatsuba_mult #(
  parameter int N = 16
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] r
);

  localparam int L = N / 2;
  localparam int H = N - L;
  localparam int W = 2 * N;

  logic [W-1:0] ah, al, bh, bl;
  logic [W-1:0] sa, sb;
  logic [W-1:0] z0, z1, z2, zm;

  assign ah = W'(a[N-1:L]);
  assign al = W'(a[L-1:0]);
  assign bh = W'(b[N-1:L]);
  assign bl = W'(b[L-1:0]);

  assign sa = ah + al;
  assign sb = bh + bl;
  assign z2 = ah * bh;
  assign z0 = al * bl;
  assign zm = sa * sb;
  // Middle term never goes negative; every partial fits in 2N bits for N >= 3.
  assign z1 = zm - z2 - z0;

  assign r = (z2 << (2 * L)) + (z1 << L) + z0;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts at ptr, wraps to 0, first requesting index wins.
module rr_arbiter
  import karatsuba_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = idw_f(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  // Walk the requesters in priority order, latching the first one found.
  always_comb begin
    req_idx_t cand;
    logic     found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = req_idx_t'(ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[cand[IDW-1:0]]) begin
        found                = 1'b1;
        gnt[cand[IDW-1:0]]   = 1'b1;
        gnt_idx              = cand[IDW-1:0];
      end else begin
        found = found;
      end
      cand = wrap_inc(cand, NREQ);
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// NREQ requesters share one Karatsuba multiplier via round-robin; products emerge
// LAT cycles after accept, tagged with the owning requester's index.
module mult_share_arbiter
  import karatsuba_pkg::*;
#(
  parameter  int N    = N_DEFAULT,
  parameter  int NREQ = NREQ_DEFAULT,
  parameter  int LAT  = 2,
  localparam int IDW  = idw_f(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   in_valid,
  output logic [NREQ-1:0]   in_ready,
  input  logic [NREQ*N-1:0] in_a,
  input  logic [NREQ*N-1:0] in_b,
  output logic              out_valid,
  output logic [IDW-1:0]    out_id,
  output logic [2*N-1:0]    out_r
);

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            accept;
  logic [N-1:0]    u, v;
  logic [2*N-1:0]  r;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            vld_q [LAT];
  logic            vld_d [LAT];
  logic [IDW-1:0]  id_q  [LAT];
  logic [IDW-1:0]  id_d  [LAT];
  logic [2*N-1:0]  r_q   [LAT];
  logic [2*N-1:0]  r_d   [LAT];

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready = gnt & {NREQ{~rst}};
  assign accept   = |in_ready;

  // One-hot AND-OR operand select feeding the shared multiplier.
  always_comb begin
    u = '0;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      u = u | (in_a[i*N +: N] & {N{gnt[i]}});
      v = v | (in_b[i*N +: N] & {N{gnt[i]}});
    end
  end

  karatsuba_mult #(
    .N (N)
  ) u_karatsuba_mult (
    .a (u),
    .b (v),
    .r (r)
  );

  // Pointer advance and pipeline next-state; data only moves alongside a valid bit
  // so the output stage holds its last result while idle.
  always_comb begin
    if (accept) begin
      ptr_d = IDW'(wrap_inc(req_idx_t'(gnt_idx), NREQ));
    end else begin
      ptr_d = ptr_q;
    end
    vld_d[0] = accept;
    id_d[0]  = accept ? gnt_idx : id_q[0];
    r_d[0]   = accept ? r : r_q[0];
    for (int s = 1; s < LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      id_d[s]  = vld_q[s-1] ? id_q[s-1] : id_q[s];
      r_d[s]   = vld_q[s-1] ? r_q[s-1] : r_q[s];
    end
  end

  // State registers; reset drops every in-flight product.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        vld_q[s] <= 1'b0;
        id_q[s]  <= '0;
        r_q[s]   <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int s = 0; s < LAT; s++) begin
        vld_q[s] <= vld_d[s];
        id_q[s]  <= id_d[s];
        r_q[s]   <= r_d[s];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_id    = id_q[LAT-1];
  assign out_r     = r_q[LAT-1];

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed and random checks of mult_share_arbiter against a queue-based reference model.
module tb_mult_share_arbiter;

  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   in_valid;
  logic [NREQ-1:0]   in_ready;
  logic [NREQ*N-1:0] in_a;
  logic [NREQ*N-1:0] in_b;
  logic              out_valid;
  logic [1:0]        out_id;
  logic [2*N-1:0]    out_r;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .N    (N),
    .NREQ (NREQ),
    .LAT  (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_r     (out_r)
  );

  typedef struct {
    int     due;
    int     id;
    longint prod;
  } exp_t;

  exp_t        q[$];
  int          p, edge_n, last_id, g_last;
  longint      last_r;
  int          vectors, miscompares;
  int unsigned accepted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first valid requester at or after p, modulo NREQ.
  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (p + k) % NREQ;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] rnd16();
    int sel;
    sel = $urandom_range(7, 0);
    if (sel == 0) return 16'hFFFF;
    if (sel == 1) return 16'h0000;
    return 16'($urandom);
  endfunction

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    in_a[i*N +: N] = a;
    in_b[i*N +: N] = b;
  endtask

  // One clock: check handshake and outputs, then advance the model on the edge.
  task automatic tick();
    int              g;
    logic [NREQ-1:0] exp_rdy;
    longint          a, b;
    #1;
    g       = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", in_ready, exp_rdy);
    if (q.size() > 0 && q[0].due == edge_n) begin
      chk("out_valid", out_valid, 1'b1);
      chk("out_id", out_id, q[0].id);
      chk("out_r", out_r, q[0].prod);
      last_id = q[0].id;
      last_r  = q[0].prod;
      void'(q.pop_front());
    end else begin
      chk("out_valid_idle", out_valid, 1'b0);
      chk("out_id_hold", out_id, last_id);
      chk("out_r_hold", out_r, last_r);
    end
    g_last = g;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      q.delete();
      p       = 0;
      last_id = 0;
      last_r  = 0;
    end else if (g >= 0) begin
      a = longint'(in_a[g*N +: N]);
      b = longint'(in_b[g*N +: N]);
      q.push_back('{edge_n + LAT - 1, g, a * b});
      p = (g + 1) % NREQ;
      accepted++;
    end
    @(negedge clk);
  endtask

  initial begin
    int unsigned acc0;
    int          cyc;
    vectors = 0; miscompares = 0;
    p = 0; edge_n = 0; last_id = 0; last_r = 0; g_last = -1; accepted = 0;
    rst = 1'b1; in_valid = '0; in_a = '0; in_b = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset state, including no grant while requests are pending.
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    tick();

    // Single requester 2: 3*5.
    rst = 1'b0;
    set_op(2, 16'd3, 16'd5);
    in_valid = 4'b0100;
    tick();
    chk("r028_grant", g_last, 2);
    in_valid = '0;
    tick();
    tick();
    chk("r028_hold_r", out_r, 32'd15);
    chk("r028_hold_id", out_id, 2'd2);
    chk("r028_vld_drop", out_valid, 1'b0);

    // Largest operands, full-width product.
    set_op(0, 16'hFFFF, 16'hFFFF);
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    tick();
    tick();
    chk("r030_product", out_r, 32'hFFFE0001);

    // All four requesting continuously from reset.
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, rnd16(), rnd16());
    in_valid = 4'hF;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("r029_order", g_last, k % 4);
      if (g_last >= 0) set_op(g_last, rnd16(), rnd16());
    end
    in_valid = '0;
    tick();
    tick();

    // Requesters 1 and 3 alternate; 0 and 2 never granted.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("r031_order", g_last, (k % 2 == 0) ? 1 : 3);
    end
    in_valid = '0;

    // Reset right after accepting requester 0 discards its product.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(0, 16'd7, 16'd9);
    set_op(1, 16'd11, 16'd13);
    in_valid = 4'b0011;
    tick();
    chk("r032_first", g_last, 0);
    in_valid = 4'b0010;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 4'b0011;
    tick();
    chk("r032_after_rst", g_last, 0);
    tick();
    chk("r032_next", g_last, 1);
    in_valid = '0;
    tick();
    tick();

    // Random traffic; requesters hold until accepted.
    acc0 = accepted;
    cyc  = 0;
    while ((accepted - acc0) < 1000 && cyc < 5000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!in_valid[i] && $urandom_range(1, 0) == 1) begin
          set_op(i, rnd16(), rnd16());
          in_valid[i] = 1'b1;
        end
      end
      tick();
      cyc++;
      if (g_last >= 0) in_valid[g_last] = 1'b0;
    end
    chk("r033_ops_done", ((accepted - acc0) >= 1000), 1'b1);

    in_valid = '0;
    repeat (LAT + 2) tick();
    chk("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
